// File: rtl/wb_arb.sv
// wb_arb: writeback arbiter and retire counter.
//   Collects results from NSRC execution pipes and routes up to NWP register
//   writes per cycle onto the register-file write ports. Sources that do not
//   write a register (wb_en=0 or dst=x0) retire without using a port.
// Ports:
//   clk, rst (async, active low)
//   src_valid/src_wb_en/src_dst/src_result/src_pc : per-source result bus
//   src_ready        : per-source accept (always 1 for non-stallable sources)
//   rf_wen/rf_wdst/rf_wdata : register-file write ports (port k = k-th grant)
//   wb_trap_instret  : number of instructions retired in the previous cycle
//   wb_conflict      : a stallable write was held back by a same-cycle dst clash
module wb_arb #(
   parameter int unsigned     XLEN         = 64,
   parameter int unsigned     NSRC         = 4,
   parameter int unsigned     NWP          = 1,
   parameter bit              RR_EN        = 1'b0,
   parameter logic [NSRC-1:0] NOSTALL_MASK = {{(NSRC-1){1'b0}}, 1'b1}
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NSRC-1:0]            src_valid,
   input  logic [NSRC-1:0]            src_wb_en,
   input  logic [NSRC*5-1:0]          src_dst,
   input  logic [NSRC*XLEN-1:0]       src_result,
   input  logic [NSRC*XLEN-1:0]       src_pc,
   output logic [NSRC-1:0]            src_ready,
   output logic [NWP-1:0]             rf_wen,
   output logic [NWP*5-1:0]           rf_wdst,
   output logic [NWP*XLEN-1:0]        rf_wdata,
   output logic [$clog2(NSRC+1)-1:0]  wb_trap_instret,
   output logic                       wb_conflict
);

   localparam int unsigned CW = $clog2(NSRC+1);
   localparam int unsigned PW = $clog2(NSRC);

   logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]          instret_q, instret_d;
   logic [NSRC-1:0]        held_q, held_d;
   logic [NSRC-1:0]        wb_en_q;
   logic [NSRC*5-1:0]      dst_q;
   logic [NSRC*XLEN-1:0]   result_q;
   logic [NSRC*XLEN-1:0]   pc_q;

   logic [NSRC-1:0]        wreq, rwb, gnt, conf;
   logic [NWP-1:0]         wen;
   logic [NWP*5-1:0]       wdst;
   logic [NWP*XLEN-1:0]    wdata;
   logic                   last_vld;
   logic [PW-1:0]          last_idx;

   // Single-pass grant. Scan positions 0..NSRC-1 visit non-stallable sources
   // in index order; positions NSRC..2*NSRC-1 visit stallable sources, either
   // in index order or rotated to start at rr_ptr.
   always_comb begin : arb
      int unsigned ng;
      int unsigned idx;
      logic        ns_pass;
      logic        hit;
      wreq     = '0;
      rwb      = '0;
      gnt      = '0;
      conf     = '0;
      wen      = '0;
      wdst     = '0;
      wdata    = '0;
      last_vld = 1'b0;
      last_idx = '0;
      ng       = 0;
      idx      = 0;
      ns_pass  = 1'b0;
      hit      = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         wreq[i] = src_valid[i] && src_wb_en[i] && (src_dst[5*i +: 5] != 5'd0);
         rwb[i]  = src_valid[i] && !wreq[i];
      end
      for (int unsigned p = 0; p < 2*NSRC; p++) begin
         ns_pass = (p < NSRC);
         if (ns_pass || !RR_EN) idx = p % NSRC;
         else                   idx = (32'(rr_ptr_q) + p) % NSRC;
         if (wreq[idx] && (NOSTALL_MASK[idx] == ns_pass) && (ng < NWP)) begin
            hit = 1'b0;
            for (int unsigned k = 0; k < NWP; k++) begin
               if ((k < ng) && (wdst[5*k +: 5] == src_dst[5*idx +: 5])) hit = 1'b1;
            end
            if (hit) begin
               conf[idx] = 1'b1;
            end else begin
               gnt[idx]               = 1'b1;
               wen[ng]                = 1'b1;
               wdst[5*ng +: 5]        = src_dst[5*idx +: 5];
               wdata[XLEN*ng +: XLEN] = src_result[XLEN*idx +: XLEN];
               ng                     = ng + 1;
               if (!ns_pass) begin
                  last_vld = 1'b1;
                  last_idx = PW'(idx);
               end
            end
         end
      end
   end

   always_comb begin : outs
      // While in reset the pipes are flushing: accept everything, write nothing.
      src_ready       = rst ? (~src_valid | gnt | rwb) : '1;
      rf_wen          = rst ? wen : '0;
      rf_wdst         = wdst;
      rf_wdata        = wdata;
      wb_conflict     = rst && (|(conf & ~NOSTALL_MASK));
      wb_trap_instret = instret_q;
      rr_ptr_d        = last_vld ? PW'((32'(last_idx) + 32'd1) % NSRC) : rr_ptr_q;
      held_d          = wreq & ~gnt & ~NOSTALL_MASK;
      instret_d       = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (src_valid[i] && src_ready[i]) instret_d = instret_d + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q  <= '0;
         instret_q <= '0;
         held_q    <= '0;
         wb_en_q   <= '0;
         dst_q     <= '0;
         result_q  <= '0;
         pc_q      <= '0;
      end else begin
         // A source stalled last cycle must present the same transaction again.
         for (int unsigned i = 0; i < NSRC; i++) begin
            if (held_q[i]) begin
               assert (src_valid[i] && src_wb_en[i] &&
                       (src_dst[5*i +: 5] == dst_q[5*i +: 5]) &&
                       (src_result[XLEN*i +: XLEN] == result_q[XLEN*i +: XLEN]) &&
                       (src_pc[XLEN*i +: XLEN] == pc_q[XLEN*i +: XLEN]));
            end
         end
         // Non-stallable writes cannot be refused (too many, or dst clash).
         assert ((wreq & NOSTALL_MASK & ~gnt) == '0);
         rr_ptr_q  <= rr_ptr_d;
         instret_q <= instret_d;
         held_q    <= held_d;
         wb_en_q   <= src_wb_en;
         dst_q     <= src_dst;
         result_q  <= src_result;
         pc_q      <= src_pc;
      end
   end

endmodule

// File: tb/tb_wb_arb.sv
module tb_wb_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [3:0]   v, we;
   logic [19:0]  dst;
   logic [255:0] res, pc;

   logic [3:0]   rdy_f1, rdy_f2, rdy_rr;
   logic [0:0]   wen_f1, wen_rr;
   logic [1:0]   wen_f2;
   logic [4:0]   wdst_f1, wdst_rr;
   logic [9:0]   wdst_f2;
   logic [63:0]  wdat_f1, wdat_rr;
   logic [127:0] wdat_f2;
   logic [2:0]   ir_f1, ir_f2, ir_rr;
   logic         cf_f1, cf_f2, cf_rr;

   int unsigned total = 0;
   int unsigned bad   = 0;

   wb_arb #(.XLEN(64), .NSRC(4), .NWP(1), .RR_EN(1'b0), .NOSTALL_MASK(4'b0001)) u_fp1 (
      .clk(clk), .rst(rst), .src_valid(v), .src_wb_en(we), .src_dst(dst),
      .src_result(res), .src_pc(pc), .src_ready(rdy_f1), .rf_wen(wen_f1),
      .rf_wdst(wdst_f1), .rf_wdata(wdat_f1), .wb_trap_instret(ir_f1), .wb_conflict(cf_f1));

   wb_arb #(.XLEN(64), .NSRC(4), .NWP(2), .RR_EN(1'b0), .NOSTALL_MASK(4'b0001)) u_fp2 (
      .clk(clk), .rst(rst), .src_valid(v), .src_wb_en(we), .src_dst(dst),
      .src_result(res), .src_pc(pc), .src_ready(rdy_f2), .rf_wen(wen_f2),
      .rf_wdst(wdst_f2), .rf_wdata(wdat_f2), .wb_trap_instret(ir_f2), .wb_conflict(cf_f2));

   wb_arb #(.XLEN(64), .NSRC(4), .NWP(1), .RR_EN(1'b1), .NOSTALL_MASK(4'b0001)) u_rr1 (
      .clk(clk), .rst(rst), .src_valid(v), .src_wb_en(we), .src_dst(dst),
      .src_result(res), .src_pc(pc), .src_ready(rdy_rr), .rf_wen(wen_rr),
      .rf_wdst(wdst_rr), .rf_wdata(wdat_rr), .wb_trap_instret(ir_rr), .wb_conflict(cf_rr));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   function automatic logic [63:0] rv(input int unsigned i);
      return 64'hF00D_0000_0000_00A0 + 64'(i);
   endfunction

   task automatic set_in(input logic [3:0] vv, input logic [3:0] ww,
                         input logic [4:0] d3, input logic [4:0] d2,
                         input logic [4:0] d1, input logic [4:0] d0);
      v   = vv;
      we  = ww;
      dst = {d3, d2, d1, d0};
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Short async reset: clears the round-robin pointer and the stall history.
   task automatic pulse();
      rst = 1'b0;
      #1;
      rst = 1'b1;
   endtask

   // Reference model: list candidates in the order the rules give, then hand
   // out ports to distinct destinations until ports run out.
   typedef struct {
      logic [3:0]   ready;
      logic [1:0]   wen;
      logic [9:0]   wdst;
      logic [127:0] wdata;
      logic         conf;
      logic         any_st;
      int unsigned  last;
      logic [2:0]   nret;
   } mres_t;

   function automatic mres_t model(input logic [3:0] vv, input logic [3:0] ww,
                                   input logic [19:0] dd, input logic [255:0] rs,
                                   input int unsigned nwp, input bit rren,
                                   input int unsigned ptr);
      mres_t       m;
      int unsigned order[$];
      logic [4:0]  taken[$];
      logic [4:0]  di;
      bit          dup;
      int unsigned i;
      int unsigned np;
      m.ready = '0; m.wen = '0; m.wdst = '0; m.wdata = '0;
      m.conf = 1'b0; m.any_st = 1'b0; m.last = 0; m.nret = '0;
      order.push_back(0);                  // source 0 is the only non-stallable one
      for (int unsigned j = 0; j < 4; j++) begin
         i = rren ? (ptr + j) % 4 : j;
         if (i != 0) order.push_back(i);
      end
      foreach (order[n]) begin
         i  = order[n];
         di = dd[5*i +: 5];
         if (!(vv[i] && ww[i] && di != 5'd0)) continue;
         if (taken.size() >= nwp) continue;
         dup = 1'b0;
         foreach (taken[t]) if (taken[t] == di) dup = 1'b1;
         if (dup) begin
            m.conf = 1'b1;
            continue;
         end
         np = taken.size();
         m.wen[np]           = 1'b1;
         m.wdst[5*np +: 5]   = di;
         m.wdata[64*np +: 64] = rs[64*i +: 64];
         taken.push_back(di);
         m.ready[i] = 1'b1;
         if (i != 0) begin
            m.any_st = 1'b1;
            m.last   = i;
         end
      end
      for (int unsigned k = 0; k < 4; k++) begin
         if (!vv[k] || !ww[k] || dd[5*k +: 5] == 5'd0) m.ready[k] = 1'b1;
         if (vv[k] && m.ready[k]) m.nret = m.nret + 3'd1;
      end
      return m;
   endfunction

   task automatic check_dut(input int unsigned id, input mres_t m, input logic [2:0] eir);
      logic [3:0]   ar;
      logic [1:0]   aw;
      logic [9:0]   ad;
      logic [127:0] aq;
      logic [2:0]   ai;
      logic         ac;
      string        nm;
      case (id)
         0:       begin ar = rdy_f1; aw = {1'b0, wen_f1}; ad = {5'd0, wdst_f1}; aq = {64'd0, wdat_f1}; ai = ir_f1; ac = cf_f1; nm = "rnd_fp1"; end
         1:       begin ar = rdy_f2; aw = wen_f2; ad = wdst_f2; aq = wdat_f2; ai = ir_f2; ac = cf_f2; nm = "rnd_fp2"; end
         default: begin ar = rdy_rr; aw = {1'b0, wen_rr}; ad = {5'd0, wdst_rr}; aq = {64'd0, wdat_rr}; ai = ir_rr; ac = cf_rr; nm = "rnd_rr1"; end
      endcase
      chk({nm, "_ready"}, 64'(ar), 64'(m.ready));
      chk({nm, "_wen"},   64'(aw), 64'(m.wen));
      chk({nm, "_wdst"},  64'(ad), 64'(m.wdst));
      chk({nm, "_wdat0"}, aq[63:0],   m.wdata[63:0]);
      chk({nm, "_wdat1"}, aq[127:64], m.wdata[127:64]);
      chk({nm, "_conf"},  64'(ac), 64'(m.conf));
      chk({nm, "_instret"}, 64'(ai), 64'(eir));
   endtask

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  we;
      logic [4:0]  d [4];
      logic [3:0]  rdy;
      logic [1:0]  wen;
      int unsigned p0;
      int unsigned p1;
      logic        cf;
      logic [2:0]  ir;
   } tv_t;

   tv_t         tv [7];
   mres_t       m [3];
   logic [2:0]  eir [3];
   int unsigned ptr_m;
   logic [3:0]  hold;

   initial begin
      // Directed vectors for the two-port fixed-priority arbiter.
      tv[0] = '{v:4'b1111, we:4'b0011, d:'{5'd8, 5'd9, 5'd10, 5'd11}, rdy:4'b1111, wen:2'b11, p0:0, p1:1, cf:1'b0, ir:3'd4};
      tv[1] = '{v:4'b1111, we:4'b1111, d:'{5'd5, 5'd6, 5'd7, 5'd8},   rdy:4'b0011, wen:2'b11, p0:0, p1:1, cf:1'b0, ir:3'd2};
      tv[2] = '{v:4'b1110, we:4'b1110, d:'{5'd0, 5'd3, 5'd3, 5'd4},   rdy:4'b1011, wen:2'b11, p0:1, p1:3, cf:1'b1, ir:3'd2};
      tv[3] = '{v:4'b0101, we:4'b0101, d:'{5'd7, 5'd0, 5'd7, 5'd0},   rdy:4'b1011, wen:2'b01, p0:0, p1:0, cf:1'b1, ir:3'd1};
      tv[4] = '{v:4'b1100, we:4'b1100, d:'{5'd0, 5'd0, 5'd0, 5'd12},  rdy:4'b1111, wen:2'b01, p0:3, p1:0, cf:1'b0, ir:3'd2};
      tv[5] = '{v:4'b0000, we:4'b0000, d:'{5'd1, 5'd2, 5'd3, 5'd4},   rdy:4'b1111, wen:2'b00, p0:0, p1:0, cf:1'b0, ir:3'd0};
      tv[6] = '{v:4'b1111, we:4'b0000, d:'{5'd1, 5'd2, 5'd3, 5'd4},   rdy:4'b1111, wen:2'b00, p0:0, p1:0, cf:1'b0, ir:3'd4};

      rst = 1'b0;
      set_in(4'b0000, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
      for (int unsigned i = 0; i < 4; i++) begin
         res[64*i +: 64] = rv(i);
         pc[64*i +: 64]  = 64'h8000_0000 + 64'(4*i);
      end

      // Reset: writes presented, yet all ready and no port enabled.
      repeat (2) @(posedge clk);
      #1;
      set_in(4'b0111, 4'b0111, 5'd0, 5'd7, 5'd6, 5'd5);
      @(negedge clk);
      chk("rst_ready_fp1", 64'(rdy_f1), 64'(4'b1111));
      chk("rst_wen_fp1",   64'(wen_f1), 64'd0);
      chk("rst_ready_rr",  64'(rdy_rr), 64'(4'b1111));
      chk("rst_wen_fp2",   64'(wen_f2), 64'd0);
      chk("rst_ir_rr",     64'(ir_rr),  64'd0);
      cyc();
      set_in(4'b0000, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
      rst = 1'b1;

      // Fixed priority, one port: src0, src1, src2 drain over three cycles.
      cyc();
      set_in(4'b0111, 4'b0111, 5'd0, 5'd7, 5'd6, 5'd5);
      @(negedge clk);
      chk("s1c0_ready", 64'(rdy_f1), 64'(4'b1001));
      chk("s1c0_wen",   64'(wen_f1), 64'd1);
      chk("s1c0_wdst",  64'(wdst_f1), 64'd5);
      chk("s1c0_wdata", wdat_f1, rv(0));
      cyc();
      set_in(4'b0110, 4'b0110, 5'd0, 5'd7, 5'd6, 5'd5);
      @(negedge clk);
      chk("s1c1_ready", 64'(rdy_f1), 64'(4'b1011));
      chk("s1c1_wdst",  64'(wdst_f1), 64'd6);
      chk("s1c1_ir",    64'(ir_f1), 64'd1);
      cyc();
      set_in(4'b0100, 4'b0100, 5'd0, 5'd7, 5'd6, 5'd5);
      @(negedge clk);
      chk("s1c2_ready", 64'(rdy_f1), 64'(4'b1111));
      chk("s1c2_wdst",  64'(wdst_f1), 64'd7);
      chk("s1c2_ir",    64'(ir_f1), 64'd1);
      cyc();
      set_in(4'b0000, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      chk("s1c3_ir",  64'(ir_f1), 64'd1);
      chk("s1c3_wen", 64'(wen_f1), 64'd0);
      cyc();
      pulse();

      // Two ports, destination clash on x3; src3 retires without a port.
      set_in(4'b1110, 4'b0110, 5'd9, 5'd3, 5'd3, 5'd0);
      @(negedge clk);
      chk("s2c0_ready", 64'(rdy_f2), 64'(4'b1011));
      chk("s2c0_wen",   64'(wen_f2), 64'(2'b01));
      chk("s2c0_wdst0", 64'(wdst_f2[4:0]), 64'd3);
      chk("s2c0_wdst1", 64'(wdst_f2[9:5]), 64'd0);
      chk("s2c0_wdata", wdat_f2[63:0], rv(1));
      chk("s2c0_conf",  64'(cf_f2), 64'd1);
      cyc();
      set_in(4'b0100, 4'b0100, 5'd9, 5'd3, 5'd3, 5'd0);
      @(negedge clk);
      chk("s2c1_ready", 64'(rdy_f2), 64'(4'b1111));
      chk("s2c1_wdst0", 64'(wdst_f2[4:0]), 64'd3);
      chk("s2c1_wdata", wdat_f2[63:0], rv(2));
      chk("s2c1_conf",  64'(cf_f2), 64'd0);
      chk("s2c1_ir",    64'(ir_f2), 64'd2);
      cyc();
      set_in(4'b0000, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      chk("s2c2_ir", 64'(ir_f2), 64'd1);
      cyc();
      pulse();

      // Round robin over sources 1..3: grant order 1,2,3,1,2,3.
      set_in(4'b1110, 4'b1110, 5'd3, 5'd2, 5'd1, 5'd0);
      for (int unsigned c = 0; c < 6; c++) begin
         if (c > 0) cyc();
         @(negedge clk);
         chk("s3_wdst",  64'(wdst_rr), 64'((c % 3) + 1));
         chk("s3_ready", 64'(rdy_rr), 64'(4'b0001 | (4'b0001 << ((c % 3) + 1))));
         if (c > 0) chk("s3_ir", 64'(ir_rr), 64'd1);
      end
      cyc();
      set_in(4'b0000, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
      pulse();

      // Write to x0 retires without a port alongside a real write.
      set_in(4'b0110, 4'b0110, 5'd0, 5'd0, 5'd4, 5'd0);
      @(negedge clk);
      chk("s4_ready", 64'(rdy_f1), 64'(4'b1111));
      chk("s4_wen",   64'(wen_f1), 64'd1);
      chk("s4_wdst",  64'(wdst_f1), 64'd4);
      chk("s4_wdata", wdat_f1, rv(1));
      cyc();
      set_in(4'b0000, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      chk("s4_ir", 64'(ir_f1), 64'd2);
      cyc();
      pulse();

      // Table-driven vectors on the two-port arbiter.
      for (int unsigned t = 0; t < 7; t++) begin
         v   = tv[t].v;
         we  = tv[t].we;
         dst = {tv[t].d[3], tv[t].d[2], tv[t].d[1], tv[t].d[0]};
         @(negedge clk);
         chk("tbl_ready", 64'(rdy_f2), 64'(tv[t].rdy));
         chk("tbl_wen",   64'(wen_f2), 64'(tv[t].wen));
         chk("tbl_wdst0", 64'(wdst_f2[4:0]), tv[t].wen[0] ? 64'(tv[t].d[tv[t].p0]) : 64'd0);
         chk("tbl_wdat0", wdat_f2[63:0],     tv[t].wen[0] ? rv(tv[t].p0) : 64'd0);
         chk("tbl_wdst1", 64'(wdst_f2[9:5]), tv[t].wen[1] ? 64'(tv[t].d[tv[t].p1]) : 64'd0);
         chk("tbl_wdat1", wdat_f2[127:64],   tv[t].wen[1] ? rv(tv[t].p1) : 64'd0);
         chk("tbl_conf",  64'(cf_f2), 64'(tv[t].cf));
         cyc();
         chk("tbl_ir",    64'(ir_f2), 64'(tv[t].ir));
         pulse();
      end

      // Reset mid-stream with rr_ptr=2 and instret=3.
      set_in(4'b1110, 4'b0010, 5'd0, 5'd0, 5'd1, 5'd0);
      @(negedge clk);
      chk("s6c0_ready", 64'(rdy_rr), 64'(4'b1111));
      cyc();
      chk("s6_ir_pre", 64'(ir_rr), 64'd3);
      set_in(4'b1110, 4'b1110, 5'd3, 5'd2, 5'd1, 5'd0);
      #1;
      chk("s6_wdst_pre", 64'(wdst_rr), 64'd2);
      rst = 1'b0;
      #1;
      chk("s6_ir_rst",    64'(ir_rr), 64'd0);
      chk("s6_ready_rst", 64'(rdy_rr), 64'(4'b1111));
      chk("s6_wen_rst",   64'(wen_rr), 64'd0);
      rst = 1'b1;
      #1;
      chk("s6_wdst_post",  64'(wdst_rr), 64'd1);
      chk("s6_ready_post", 64'(rdy_rr), 64'(4'b0011));
      cyc();
      set_in(4'b0000, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
      pulse();

      // Randomized traffic against the reference model, honouring the
      // hold-until-ready rule for every stalled source.
      ptr_m = 0;
      for (int unsigned k = 0; k < 3; k++) eir[k] = 3'd0;
      hold = 4'b0000;
      for (int unsigned n = 0; n < 400; n++) begin
         cyc();
         for (int unsigned i = 0; i < 4; i++) begin
            if (!hold[i]) begin
               v[i]            = ($urandom_range(0, 9) < 7);
               we[i]           = ($urandom_range(0, 3) != 0);
               dst[5*i +: 5]   = 5'($urandom_range(0, 3));
               res[64*i +: 64] = {$urandom, $urandom};
               pc[64*i +: 64]  = {$urandom, $urandom};
            end
         end
         @(negedge clk);
         m[0] = model(v, we, dst, res, 1, 1'b0, 0);
         m[1] = model(v, we, dst, res, 2, 1'b0, 0);
         m[2] = model(v, we, dst, res, 1, 1'b1, ptr_m);
         for (int unsigned k = 0; k < 3; k++) begin
            check_dut(k, m[k], eir[k]);
            eir[k] = m[k].nret;
         end
         if (m[2].any_st) ptr_m = (m[2].last + 1) % 4;
         hold = v & ~(m[0].ready & m[1].ready & m[2].ready);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
